// File: rtl/axis_frame_pkg.sv
// Shared types and constants for the AXI4-Stream frame-length limiter.
package axis_frame_pkg;

    localparam int LEN_WIDTH_DEFAULT = 16;
    localparam int USER_BAD_BIT      = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } trunc_state_e;

endpackage

// File: rtl/axis_frame_trunc_stats.sv
// Free-running frame and truncation counters for axis_frame_trunc.
module axis_frame_trunc_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_done,
    input  logic        frame_trunc,
    output logic [31:0] stat_frames,
    output logic [31:0] stat_trunc
);

    logic [31:0] frames_q, frames_d;
    logic [31:0] trunc_q, trunc_d;

    always_comb begin
        frames_d = frames_q;
        trunc_d  = trunc_q;
        if (frame_done) begin
            frames_d = frames_q + 32'd1;
        end
        if (frame_trunc) begin
            trunc_d = trunc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frames_q <= '0;
            trunc_q  <= '0;
        end else begin
            frames_q <= frames_d;
            trunc_q  <= trunc_d;
        end
    end

    assign stat_frames = frames_q;
    assign stat_trunc  = trunc_q;

endmodule

// File: rtl/axis_frame_trunc.sv
// AXI4-Stream frame-length limiter: cuts oversize frames at cfg_max_len and marks them bad.
// Optional statistics counters are enabled with AXIS_FRAME_TRUNC_STATS_EN.
module axis_frame_trunc
    import axis_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready,
    input  logic [LEN_WIDTH-1:0]  cfg_max_len,
    output logic                  status_truncated,
    output logic [LEN_WIDTH-1:0]  status_frame_len,
    output logic                  status_frame_len_valid
`ifdef AXIS_FRAME_TRUNC_STATS_EN
    ,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_trunc
`endif
);

    trunc_state_e          state_q, state_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]  max_len_q, max_len_d;

    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;

    logic                  truncated_q, truncated_d;
    logic [LEN_WIDTH-1:0]  frame_len_q, frame_len_d;
    logic                  frame_len_valid_q, frame_len_valid_d;

    logic                  s_ready;
    logic                  accept;
    logic                  load;
    logic                  trunc;
    logic                  at_limit;
    logic [LEN_WIDTH-1:0]  cnt_cur;
    logic [LEN_WIDTH-1:0]  max_cur;

    // DROP sinks beats unconditionally; otherwise the single output register gates input.
    assign s_ready = (state_q == DROP) || m_axis_tready || !m_tvalid_q;
    assign accept  = s_axis_tvalid && s_ready;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        max_len_d  = max_len_q;
        load       = 1'b0;
        trunc      = 1'b0;
        cnt_cur    = beat_cnt_q;
        max_cur    = max_len_q;

        // The limit is sampled only on a frame's first beat; the count never wraps.
        if (state_q == IDLE) begin
            cnt_cur = LEN_WIDTH'(1);
            max_cur = cfg_max_len;
        end else if (beat_cnt_q != {LEN_WIDTH{1'b1}}) begin
            cnt_cur = beat_cnt_q + LEN_WIDTH'(1);
        end
        at_limit = (max_cur != '0) && (cnt_cur == max_cur);

        if (accept) begin
            if (state_q == DROP) begin
                if (s_axis_tlast) begin
                    state_d = IDLE;
                end
            end else begin
                load       = 1'b1;
                trunc      = at_limit && !s_axis_tlast;
                beat_cnt_d = cnt_cur;
                max_len_d  = max_cur;
                if (trunc) begin
                    state_d = DROP;
                end else if (s_axis_tlast) begin
                    state_d = IDLE;
                end else begin
                    state_d = PASS;
                end
            end
        end
    end

    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;
        m_tvalid_d = m_tvalid_q;
        if (load) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = s_axis_tdata;
            m_tkeep_d  = s_axis_tkeep;
            m_tlast_d  = s_axis_tlast || trunc;
            m_tuser_d  = s_axis_tuser;
            m_tuser_d[USER_BAD_BIT] = s_axis_tuser[USER_BAD_BIT] || trunc;
        end else if (m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end

        truncated_d       = trunc;
        frame_len_valid_d = load && (s_axis_tlast || trunc);
        frame_len_d       = frame_len_valid_d ? cnt_cur : frame_len_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= IDLE;
            beat_cnt_q        <= '0;
            max_len_q         <= '0;
            m_tvalid_q        <= 1'b0;
            truncated_q       <= 1'b0;
            frame_len_q       <= '0;
            frame_len_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            beat_cnt_q        <= beat_cnt_d;
            max_len_q         <= max_len_d;
            m_tvalid_q        <= m_tvalid_d;
            truncated_q       <= truncated_d;
            frame_len_q       <= frame_len_d;
            frame_len_valid_q <= frame_len_valid_d;
        end
    end

    // Payload fields are qualified by m_tvalid_q and need no reset.
    always_ff @(posedge clk) begin
        m_tdata_q <= m_tdata_d;
        m_tkeep_q <= m_tkeep_d;
        m_tlast_q <= m_tlast_d;
        m_tuser_q <= m_tuser_d;
    end

    assign s_axis_tready          = s_ready;
    assign m_axis_tdata           = m_tdata_q;
    assign m_axis_tkeep           = m_tkeep_q;
    assign m_axis_tvalid          = m_tvalid_q;
    assign m_axis_tlast           = m_tlast_q;
    assign m_axis_tuser           = m_tuser_q;
    assign status_truncated       = truncated_q;
    assign status_frame_len       = frame_len_q;
    assign status_frame_len_valid = frame_len_valid_q;

`ifdef AXIS_FRAME_TRUNC_STATS_EN
    axis_frame_trunc_stats u_stats (
        .clk         (clk),
        .rst         (rst),
        .frame_done  (frame_len_valid_q),
        .frame_trunc (truncated_q),
        .stat_frames (stat_frames),
        .stat_trunc  (stat_trunc)
    );
`endif

endmodule

// File: tb/tb_axis_frame_trunc.sv
// Randomized bench for axis_frame_trunc with a frame-level reference model and scoreboard.
module tb_axis_frame_trunc;

    localparam int DW = 16;
    localparam int KW = 2;
    localparam int UW = 2;
    localparam int LW = 8;
    localparam int CNT_MAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic [UW-1:0] s_tuser = '0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tlast;
    logic [UW-1:0] m_tuser;
    logic          m_tready = 1'b1;
    logic [LW-1:0] cfg_max_len = '0;
    logic          st_trunc;
    logic [LW-1:0] st_len;
    logic          st_len_valid;
`ifdef AXIS_FRAME_TRUNC_STATS_EN
    logic [31:0]   stat_frames;
    logic [31:0]   stat_trunc;
`endif

    always #5 clk = ~clk;

    axis_frame_trunc #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .USER_WIDTH (UW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_axis_tdata           (s_tdata),
        .s_axis_tkeep           (s_tkeep),
        .s_axis_tvalid          (s_tvalid),
        .s_axis_tlast           (s_tlast),
        .s_axis_tuser           (s_tuser),
        .s_axis_tready          (s_tready),
        .m_axis_tdata           (m_tdata),
        .m_axis_tkeep           (m_tkeep),
        .m_axis_tvalid          (m_tvalid),
        .m_axis_tlast           (m_tlast),
        .m_axis_tuser           (m_tuser),
        .m_axis_tready          (m_tready),
        .cfg_max_len            (cfg_max_len),
        .status_truncated       (st_trunc),
        .status_frame_len       (st_len),
        .status_frame_len_valid (st_len_valid)
`ifdef AXIS_FRAME_TRUNC_STATS_EN
        ,
        .stat_frames            (stat_frames),
        .stat_trunc             (stat_trunc)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW+KW+1+UW-1:0] exp_beats[$];
    int exp_lens[$];
    int exp_trunc  = 0;
    int exp_frames = 0;
    int seen_trunc = 0;
    bit mon_en     = 1'b0;
    bit rand_rdy   = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (m_tvalid && m_tready) begin
                    if (exp_beats.size() == 0) chk("extra_beat", 64'd1, 64'd0);
                    else chk("beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, exp_beats.pop_front());
                end
                if (st_len_valid) begin
                    if (exp_lens.size() == 0) chk("extra_len", 64'd1, 64'd0);
                    else chk("frame_len", st_len, exp_lens.pop_front());
                end
                if (st_trunc) seen_trunc++;
            end
        end
    end

    // Present one beat (caller sits just after a rising edge) and hold it until accepted.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input logic [UW-1:0] u);
        bit acc;
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        n = 0;
        do begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 1000);
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        s_tvalid = 1'b0;
    endtask

    // Reference: the frame keeps min(len, limit) beats; a cut frame ends on a bad, tlast beat.
    task automatic send_frame(input int len, input int cfg_start, input int cfg_change,
                              input int change_at, input bit gaps);
        logic [DW-1:0] d[];
        logic [KW-1:0] k[];
        logic [UW-1:0] u[];
        int nout;
        bit tr;
        d = new[len];
        k = new[len];
        u = new[len];
        for (int i = 0; i < len; i++) begin
            d[i] = DW'($urandom);
            k[i] = KW'($urandom);
            u[i] = UW'($urandom);
        end
        nout = (cfg_start == 0 || len <= cfg_start) ? len : cfg_start;
        tr   = (nout < len);
        for (int i = 0; i < nout; i++) begin
            logic          last;
            logic [UW-1:0] ue;
            last = (i == len - 1) || (tr && i == nout - 1);
            ue   = u[i];
            if (tr && i == nout - 1) ue[0] = 1'b1;
            exp_beats.push_back({d[i], k[i], last, ue});
        end
        exp_lens.push_back(nout > CNT_MAX ? CNT_MAX : nout);
        exp_frames++;
        if (tr) exp_trunc++;
        $display("frame len=%0d max=%0d -> beats_out=%0d truncated=%0d", len, cfg_start, nout, tr);

        cfg_max_len = LW'(cfg_start);
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(d[i], k[i], (i == len - 1), u[i]);
            if (i + 1 == change_at) cfg_max_len = LW'(cfg_change);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_lens.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_beats_left", 64'(exp_beats.size()), 64'd0);
        chk("drain_lens_left", 64'(exp_lens.size()), 64'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_trunc", st_trunc, 1'b0);
        chk("rst_len_valid", st_len_valid, 1'b0);
        chk("rst_len", st_len, 0);
        rst    = 1'b1;
        mon_en = 1'b1;

        send_frame(3, 4, 4, 0, 1'b0);
        send_frame(10, 4, 4, 0, 1'b0);
        send_frame(4, 4, 4, 0, 1'b0);
        rand_rdy = 1'b1;
        send_frame(300, 0, 0, 0, 1'b0);
        send_frame(6, 8, 2, 3, 1'b1);
        send_frame(6, 2, 2, 0, 1'b1);
        send_frame(5, 1, 1, 0, 1'b0);
        send_frame(1, 1, 1, 0, 1'b0);
        send_frame(7, 0, 0, 0, 1'b1);
        drain();
        chk("trunc_pulses", 64'(seen_trunc), 64'(exp_trunc));

        // Reset in the middle of a frame that would truncate at 2 beats.
        rand_rdy    = 1'b0;
        m_tready    = 1'b1;
        mon_en      = 1'b0;
        cfg_max_len = LW'(2);
        send_beat(DW'(16'h1111), KW'(2'b11), 1'b0, UW'(2'b00));
        s_tvalid = 1'b1;
        s_tdata  = DW'(16'h2222);
        s_tlast  = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        s_tvalid = 1'b0;
        chk("midrst_tvalid", m_tvalid, 1'b0);
        chk("midrst_len", st_len, 0);
        chk("midrst_trunc", st_trunc, 1'b0);
`ifdef AXIS_FRAME_TRUNC_STATS_EN
        chk("midrst_stat_frames", stat_frames, 0);
        chk("midrst_stat_trunc", stat_trunc, 0);
`endif
        @(posedge clk);
        #1;
        exp_beats.delete();
        exp_lens.delete();
        exp_frames = 0;
        exp_trunc  = 0;
        seen_trunc = 0;
        mon_en     = 1'b1;
        send_frame(3, 4, 4, 0, 1'b0);

        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            send_frame($urandom_range(1, 20), $urandom_range(0, 12), 0, 0, 1'b1);
            cfg_max_len = '0;
        end
        drain();
        chk("trunc_pulses_rand", 64'(seen_trunc), 64'(exp_trunc));
`ifdef AXIS_FRAME_TRUNC_STATS_EN
        chk("stat_frames", stat_frames, 32'(exp_frames));
        chk("stat_trunc", stat_trunc, 32'(exp_trunc));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
